spi_neopix_multi: RTL and testbench
===================================

# spi_neopix_multi

Parametrised multi-channel SPI-to-WS2812 bridge. One SPI slave receiver (mode 0) is shared by NUM_CH channels, each with its own active-low select, pixel buffer and WS2812 serializer. It is the next generation of the per-channel SPI-to-NeoPixel bridge at the board top level: the SPI front end is no longer duplicated per channel, channels can be written in broadcast, refresh requests that arrive while a channel is busy are queued, and per-channel busy status is exported.

## Interface
- NUM_CH, 2, number of channels, 1..8
- NUM_LEDS, 256, pixels per channel, 3 bytes each
- T0H, 20, DO high cycles for a 0 bit
- T1H, 40, DO high cycles for a 1 bit
- TBIT, 62, total cycles per bit; must be greater than T1H
- RESET_CYCLES, 2800, DO low latch cycles after the last bit (56 µs)

- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- SCK  in  1  SPI clock, asynchronous, at most CLOCK_50/8
- MOSI  in  1  SPI data, sampled on the SCK rising edge
- SSEL  in  NUM_CH  per-channel select, active low
- MISO  out  1  SPI data out
- DO  out  NUM_CH  WS2812 data lines
- BUSY  out  NUM_CH  channel refresh in progress

## Operation
- SCK, MOSI and each SSEL bit pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- Receiver:
  - An SSEL falling edge on any channel clears the bit counter and the byte address.
  - Each synchronized SCK rise shifts MOSI in, MSB first.
  - Every 8th bit completes a byte, which is written at the current byte address into the buffer of every channel whose SSEL is low. The address then increments.
  - Addresses at or above 3*NUM_LEDS are ignored. There is no wrap.
  - A partial byte left when select rises is discarded.
- Per-channel request:
  - A channel's SSEL rising edge sets its request flag if at least one byte was written to it during that select window.
  - If SSEL goes high with zero bytes, no request is made.
- Serializer FSM per channel, states IDLE, LOAD, HIGH, LOW, LATCH:
  - IDLE: when the request flag is set, clear it, set BUSY, go to LOAD.
  - LOAD: fetch byte 0 and set bit index 7.
  - HIGH: DO=1 for T1H cycles (bit=1) or T0H cycles (bit=0).
  - LOW: DO=0 for the rest of TBIT. Then advance to the next bit. After bit 0, fetch the next byte.
  - After the last bit of byte 3*NUM_LEDS−1, go to LATCH.
  - LATCH: DO=0 for RESET_CYCLES. If the request flag is set, go to LOAD with BUSY held high; otherwise go to IDLE and clear BUSY.
- Byte order on the wire matches receive order: pixel 0 byte 0 is first (G,R,B per pixel), MSB first. The full buffer is always sent, including bytes not rewritten this frame.
- Writes to a busy channel go straight into its live buffer. Tearing is accepted. The queued request guarantees a full refresh afterward.
- Buffers are not cleared by reset; their contents are undefined until written.

## Timing
- Reset values: DO=0, BUSY=0, MISO=1. All FSMs are in IDLE, request flags and counters are cleared.
- Reset asserted mid-frame: DO=0 and BUSY=0 on the next edge. Any pending request is lost.
- The first DO rising edge comes no more than 5 CLOCK_50 cycles after the SSEL pin rises.
- Bit period is exactly TBIT cycles.
- Frame duration: 24*NUM_LEDS*TBIT + RESET_CYCLES cycles, with BUSY high for the whole frame.
- Simultaneous completion of a byte and an SSEL rise in the same cycle: the byte is written first, then the request is evaluated including that byte.
- A request arriving in the same cycle that LATCH ends is taken: the FSM goes straight to LOAD.

## Configuration
- SPI_STATUS_EN defined:
  - MISO shifts out a status byte per SPI byte: bit i = BUSY[i], upper bits zero, MSB first.
  - The byte is latched at the SSEL falling edge or at byte completion. Bits update on the synchronized SCK falling edge.
  - MISO is 1 when no SSEL is low.
- SPI_STATUS_EN undefined: MISO is tied to 1.

## Test plan
- Reset: hold reset 3 cycles -> DO=0, BUSY=0, MISO=1. No DO activity for 10 µs.
- NUM_LEDS=2, channel 0, write 0x80,0x00,0xFF,0x01,0x02,0x03:
  - DO[0] first bit high 40 and low 22 cycles; next bit high 20 cycles.
  - BUSY[0] high for 48*62+2800 cycles.
  - DO[1] stays 0.
- Broadcast: SSEL=2'b00, write 0xA5,0x5A,0xFF -> DO[0] and DO[1] are identical, cycle-for-cycle, for the first 24 bits.
- Overflow and partial byte, NUM_LEDS=2: write 7 bytes plus 4 extra bits -> the 7th byte and the partial byte are ignored. The transmitted frame is the first 6 bytes.
- Queued refresh: issue a second frame while BUSY[0]=1 -> BUSY[0] stays high continuously and a second full frame follows LATCH immediately. An empty select pulse (0 bytes) queues nothing.
- Reset mid-frame, and with SPI_STATUS_EN while channel 1 is busy: reset -> DO=0 and BUSY=0 next cycle. With channel 1 busy, the status read returns 0x02.

Source files
------------

// File: rtl/spi_neopix_multi.sv
// Multi-channel SPI (mode 0) to WS2812 bridge: one shared receiver, per-channel buffer and serializer.
// Optional MISO status readback enabled by defining SPI_STATUS_EN.
module spi_neopix_multi #(
  parameter int NUM_CH       = 2,
  parameter int NUM_LEDS     = 256,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 62,
  parameter int RESET_CYCLES = 2800
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic [NUM_CH-1:0] SSEL,
  output logic              MISO,
  output logic [NUM_CH-1:0] DO,
  output logic [NUM_CH-1:0] BUSY
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int AW     = $clog2(NBYTES + 1);
  localparam int CMAX   = (RESET_CYCLES > TBIT) ? RESET_CYCLES : TBIT;
  localparam int CW     = $clog2(CMAX + 1);
  localparam logic [AW-1:0] ADDR_END = AW'(NBYTES);

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

  // sck_sr: [0] meta, [1] synchronized, [2] previous synchronized value
  logic [2:0]        sck_sr;
  logic [1:0]        mosi_sr;
  logic [NUM_CH-1:0] ssel_m, ssel_s, ssel_p;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sck_sr  <= '0;
      mosi_sr <= '0;
      ssel_m  <= '1;
      ssel_s  <= '1;
      ssel_p  <= '1;
    end else begin
      sck_sr  <= {sck_sr[1:0], SCK};
      mosi_sr <= {mosi_sr[0], MOSI};
      ssel_m  <= SSEL;
      ssel_s  <= ssel_m;
      ssel_p  <= ssel_s;
    end
  end

  logic              sck_rise, any_fall, any_win, byte_done, in_range;
  logic [NUM_CH-1:0] ssel_fall, ssel_rise, sel_win, wr_en;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [AW-1:0]     addr;
  logic [7:0]        wdata;

  // A channel stays in its window through the cycle its select rise is seen,
  // so a byte completing in that same cycle is still written and counted.
  assign sck_rise  = sck_sr[1] & ~sck_sr[2];
  assign ssel_fall = ~ssel_s & ssel_p;
  assign ssel_rise = ssel_s & ~ssel_p;
  assign sel_win   = ~(ssel_s & ssel_p);
  assign any_fall  = |ssel_fall;
  assign any_win   = |sel_win;
  assign in_range  = (addr < ADDR_END);
  assign byte_done = sck_rise & any_win & ~any_fall & (bit_cnt == 3'd7);
  assign wdata     = {shreg, mosi_sr[1]};
  assign wr_en     = (byte_done && in_range) ? sel_win : '0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      addr    <= '0;
    end else if (any_fall) begin
      bit_cnt <= '0;
      addr    <= '0;
    end else if (!any_win) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      shreg   <= {shreg[5:0], mosi_sr[1]};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7 && in_range) addr <= addr + AW'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0]    mem [NBYTES];
    logic [7:0]    rd_q;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [AW-1:0] rd_idx, rd_idx_n;
    logic          req, written, req_set, pend, take, do_q, busy_q;
    logic [CW-1:0] high_last;

    // Write-first read so a byte landing as the frame starts is already visible in LOAD.
    always_ff @(posedge CLOCK_50) begin
      if (wr_en[g]) mem[addr] <= wdata;
      rd_q <= (wr_en[g] && addr == rd_idx) ? wdata : mem[rd_idx];
    end

    assign req_set   = ssel_rise[g] & (written | wr_en[g]);
    assign pend      = req | req_set;
    assign high_last = shift[bit_idx] ? CW'(T1H - 1) : CW'(T0H - 1);

    // rd_idx always points at the next byte to fetch; it wraps to 0 when the
    // last byte is loaded, which both marks the final byte and pre-reads byte 0.
    // LATCH lasts RESET_CYCLES-1 so that with the LOAD cycle the low gap and
    // the frame length come out exact.
    always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      rd_idx_n  = rd_idx;
      take      = 1'b0;
      case (state)
        IDLE: if (pend) begin
          take    = 1'b1;
          state_n = LOAD;
        end
        LOAD: begin
          shift_n   = rd_q;
          bit_idx_n = 3'd7;
          rd_idx_n  = AW'(1);
          cnt_n     = '0;
          state_n   = HIGH;
        end
        HIGH: begin
          cnt_n = cnt + CW'(1);
          if (cnt == high_last) state_n = LOW;
        end
        LOW: begin
          if (cnt == CW'(TBIT - 1)) begin
            cnt_n   = '0;
            state_n = HIGH;
            if (bit_idx != 3'd0) begin
              bit_idx_n = bit_idx - 3'd1;
            end else if (rd_idx == '0) begin
              state_n = LATCH;
            end else begin
              shift_n   = rd_q;
              bit_idx_n = 3'd7;
              rd_idx_n  = (rd_idx == AW'(NBYTES - 1)) ? '0 : rd_idx + AW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        LATCH: begin
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(RESET_CYCLES - 2)) begin
            cnt_n = '0;
            if (pend) begin
              take    = 1'b1;
              state_n = LOAD;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        shift   <= '0;
        rd_idx  <= '0;
        req     <= 1'b0;
        written <= 1'b0;
        do_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state   <= state_n;
        cnt     <= cnt_n;
        bit_idx <= bit_idx_n;
        shift   <= shift_n;
        rd_idx  <= rd_idx_n;
        req     <= pend & ~take;
        if (ssel_fall[g])  written <= 1'b0;
        else if (wr_en[g]) written <= 1'b1;
        do_q    <= (state_n == HIGH);
        busy_q  <= (state_n != IDLE);
      end
    end

    assign DO[g]   = do_q;
    assign BUSY[g] = busy_q;
  end

`ifdef SPI_STATUS_EN
  logic       sck_fall;
  logic [7:0] stat_sr, stat_val;

  assign sck_fall = ~sck_sr[1] & sck_sr[2];

  always_comb begin
    stat_val             = '0;
    stat_val[NUM_CH-1:0] = BUSY;
  end

  // The falling edge right after a completed byte is skipped so the freshly
  // latched MSB stays on the line for the next byte's first rise.
  always_ff @(posedge CLOCK_50) begin
    if (reset)                                        stat_sr <= '0;
    else if (any_fall || byte_done)                   stat_sr <= stat_val;
    else if (sck_fall && any_win && bit_cnt != 3'd0)  stat_sr <= {stat_sr[6:0], 1'b0};
  end

  assign MISO = (&ssel_s) ? 1'b1 : stat_sr[7];
`else
  assign MISO = 1'b1;
`endif

endmodule

// File: tb/tb_spi_neopix_multi.sv
// Self-checking bench for spi_neopix_multi (2 channels, 2 LEDs each): table vectors,
// hand sequences for queued refresh and reset, and random writes against a buffer model.
module tb_spi_neopix_multi;

  localparam int NCH   = 2;
  localparam int NL    = 2;
  localparam int NB    = 3 * NL;
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int TBIT  = 62;
  localparam int RST   = 2800;
  localparam int FRAME = 24 * NL * TBIT + RST;
`ifdef SPI_STATUS_EN
  localparam logic [7:0] MISO_IDLE  = 8'h00;
  localparam logic [7:0] STATUS_CH1 = 8'h02;
`else
  localparam logic [7:0] MISO_IDLE  = 8'hFF;
  localparam logic [7:0] STATUS_CH1 = 8'hFF;
`endif

  logic           clk = 1'b0;
  logic           reset, SCK, MOSI, MISO;
  logic [NCH-1:0] SSEL, DO, BUSY;

  always #10 clk = ~clk;

  spi_neopix_multi #(
    .NUM_CH(NCH), .NUM_LEDS(NL), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RST)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL),
    .MISO(MISO), .DO(DO), .BUSY(BUSY)
  );

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     run_c[NCH] = '{0, 0};
  int     last_run[NCH] = '{0, 0};
  logic [7:0] tx[9];
  logic [7:0] mem_m[NCH][NB];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (BUSY[c] === 1'b1) run_c[c]++;
      else begin
        if (run_c[c] != 0) last_run[c] = run_c[c];
        run_c[c] = 0;
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [47:0] model_frame(input int ch);
    logic [47:0] f = '0;
    for (int i = 0; i < NB; i++) f = {f[39:0], mem_m[ch][i]};
    return f;
  endfunction

  // SPI master, mode 0, SCK at CLOCK_50/8; returns the first MISO byte seen.
  task automatic spi_xfer(input logic [1:0] sel, input int nb, input int xbits, output logic [7:0] m);
    logic [7:0] cur;
    int total;
    m = '1;
    total = nb * 8 + xbits;
    @(negedge clk);
    SSEL = sel;
    repeat (8) @(negedge clk);
    for (int k = 0; k < total; k++) begin
      cur  = tx[k / 8];
      MOSI = cur[7 - (k % 8)];
      repeat (4) @(negedge clk);
      if (k < 8) m[7 - k] = MISO;
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (8) @(negedge clk);
    SSEL = '1;
    for (int i = 0; i < nb && i < NB; i++)
      for (int c = 0; c < NCH; c++)
        if (!sel[c]) mem_m[c][i] = tx[i];
  endtask

  // Decodes one frame from DO[ch]; errs counts bad high widths or bit periods.
  task automatic capture(input int ch, input int bound, output logic [47:0] got,
                         output int errs, output longint t_rise, output int w);
    int h, l;
    got = '0; errs = 0; t_rise = 0; w = 0;
    while (DO[ch] !== 1'b1 && w < bound) begin @(negedge clk); w++; end
    if (DO[ch] !== 1'b1) begin errs = 1000; return; end
    t_rise = cyc;
    for (int b = 0; b < 48; b++) begin
      h = 0;
      while (DO[ch] === 1'b1 && h <= TBIT) begin h++; @(negedge clk); end
      got = {got[46:0], (h == T1H)};
      if (h != T1H && h != T0H) errs++;
      if (b < 47) begin
        l = 0;
        while (DO[ch] === 1'b0 && l <= TBIT) begin l++; @(negedge clk); end
        if (h + l != TBIT) errs++;
      end
    end
  endtask

  task automatic quiet(input int ch, input int n, output int highs);
    highs = 0;
    repeat (n) begin @(negedge clk); if (DO[ch] !== 1'b0) highs++; end
  endtask

  task automatic wait_idle(input int ch, input int bound);
    int k = 0;
    while (BUSY[ch] === 1'b1 && k < bound) begin @(negedge clk); k++; end
    @(negedge clk);
  endtask

  task automatic chan_check(input int ch, input bit on, input logic [47:0] exp, input string tag);
    logic [47:0] got; int errs, w, hi; longint tr;
    if (on) begin
      capture(ch, 20, got, errs, tr, w);
      check($sformatf("%s_ch%0d_latency_le5", tag, ch), 64'(w <= 5), 64'd1);
      check($sformatf("%s_ch%0d_bit_timing_errs", tag, ch), 64'(errs), 64'd0);
      check($sformatf("%s_ch%0d_frame", tag, ch), 64'(got), 64'(exp));
      wait_idle(ch, RST + 200);
      check($sformatf("%s_ch%0d_busy_len", tag, ch), 64'(last_run[ch]), 64'(FRAME));
    end else begin
      quiet(ch, FRAME + 100, hi);
      check($sformatf("%s_ch%0d_quiet", tag, ch), 64'(hi), 64'd0);
    end
  endtask

  task automatic run_frame(input logic [1:0] sel, input int nb, input int xbits, input bit use_model,
                           input logic [47:0] e0, input logic [47:0] e1, input bit lockstep,
                           input string tag);
    logic [7:0] m; int diff;
    spi_xfer(sel, nb, xbits, m);
    check($sformatf("%s_miso", tag), 64'(m), 64'(MISO_IDLE));
    if (use_model) begin e0 = model_frame(0); e1 = model_frame(1); end
    fork
      chan_check(0, !sel[0], e0, tag);
      chan_check(1, !sel[1], e1, tag);
      begin
        if (lockstep) begin
          diff = 0;
          repeat (24 * TBIT + 20) begin @(negedge clk); if (DO[0] !== DO[1]) diff++; end
          check($sformatf("%s_lockstep_diffs", tag), 64'(diff), 64'd0);
        end
      end
    join
  endtask

  typedef struct {
    logic [1:0]  sel;
    int          nb;
    logic [63:0] d;
    int          xbits;
    logic [47:0] exp0;
    logic [47:0] exp1;
    bit          lockstep;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [7:0]  m;
    logic [47:0] ga, gb;
    int          ea, eb, wa, wb, hi0, hi1;
    longint      ta, tb;
    logic [1:0]  rsel;

    vt[0] = '{2'b10, 6, 64'h8000FF0102030000, 0, 48'h8000FF010203, 48'h0, 1'b0};
    vt[1] = '{2'b01, 6, 64'h1122334455660000, 0, 48'h0, 48'h112233445566, 1'b0};
    vt[2] = '{2'b00, 3, 64'hA55AFF0000000000, 0, 48'hA55AFF010203, 48'hA55AFF445566, 1'b1};
    vt[3] = '{2'b10, 7, 64'hC33C0FF0AA55EEA0, 4, 48'hC33C0FF0AA55, 48'h0, 1'b0};

    SCK = 1'b0; MOSI = 1'b0; SSEL = '1; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_do", 64'(DO), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_miso", 64'(MISO), 64'd1);
    reset = 1'b0;
    fork quiet(0, 500, hi0); quiet(1, 500, hi1); join
    check("post_reset_quiet", 64'(hi0 + hi1), 64'd0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 8; i++) tx[i] = vt[v].d[63 - 8 * i -: 8];
      run_frame(vt[v].sel, vt[v].nb, vt[v].xbits, 1'b0, vt[v].exp0, vt[v].exp1,
                vt[v].lockstep, $sformatf("vec%0d", v));
    end

    // Queued refresh: second frame written during LATCH, empty pulse during frame two.
    tx[0] = 8'h66; tx[1] = 8'h77; tx[2] = 8'h88; tx[3] = 8'h99; tx[4] = 8'hAA; tx[5] = 8'hBB;
    spi_xfer(2'b10, 6, 0, m);
    fork
      begin
        capture(0, 20, ga, ea, ta, wa);
        capture(0, RST + 2 * TBIT, gb, eb, tb, wb);
        wait_idle(0, RST + 200);
      end
      begin
        repeat (3200) @(negedge clk);
        for (int i = 0; i < 6; i++) tx[i] = 8'(i + 1);
        spi_xfer(2'b10, 6, 0, m);
        repeat (3500) @(negedge clk);
        spi_xfer(2'b10, 0, 0, m);
      end
    join
    check("queue_frame_a", 64'(ga), 64'h66778899AABB);
    check("queue_timing_errs", 64'(ea + eb), 64'd0);
    check("queue_frame_b", 64'(gb), 64'(model_frame(0)));
    check("queue_frame_spacing", 64'(tb - ta), 64'(FRAME));
    check("queue_busy_len", 64'(last_run[0]), 64'(2 * FRAME));
    quiet(0, 300, hi0);
    check("empty_pulse_no_frame", 64'(hi0), 64'd0);
    check("empty_pulse_busy", 64'(BUSY[0]), 64'd0);

    for (int r = 0; r < 3; r++) begin
      case ($urandom_range(0, 2))
        0:       rsel = 2'b10;
        1:       rsel = 2'b01;
        default: rsel = 2'b00;
      endcase
      for (int i = 0; i < 9; i++) tx[i] = 8'($urandom);
      run_frame(rsel, $urandom_range(1, 7), $urandom_range(0, 7), 1'b1, '0, '0, 1'b0,
                $sformatf("rand%0d", r));
    end

    // Status read while channel 1 busy, then reset in the middle of both frames.
    tx[0] = 8'hF0; tx[1] = 8'h0F; tx[2] = 8'hCC; tx[3] = 8'h33; tx[4] = 8'h5A; tx[5] = 8'hA5;
    spi_xfer(2'b01, 6, 0, m);
    repeat (100) @(negedge clk);
    tx[0] = 8'h12;
    spi_xfer(2'b10, 1, 0, m);
    check("status_read_ch1_busy", 64'(m), 64'(STATUS_CH1));
    repeat (50) @(negedge clk);
    check("both_busy", 64'(BUSY), 64'h3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_do", 64'(DO), 64'd0);
    check("rst_mid_busy", 64'(BUSY), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fork quiet(0, 500, hi0); quiet(1, 500, hi1); join
    check("rst_mid_request_lost", 64'(hi0 + hi1), 64'd0);
    check("rst_mid_busy_after", 64'(BUSY), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
